// File: rtl/sipo_frame_rx.sv
// Serial-in frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// All state moves on the falling edge of CLK. A good frame lands in a one-deep output register with a valid/ready handshake.
module sipo_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Sin,
  output logic [DATA_W-1:0] Dout,
  output logic              Dvalid,
  input  logic              Dready,
  output logic              ParErr,
  output logic              FrmErr,
  output logic              Overrun,
  output logic              Busy
);

  localparam int CW = $clog2(DATA_W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bad;
  logic              good_frame;

  // A frame is good only when the stop bit is 1 and no parity fault was recorded.
  assign good_frame = (state == STOP) && Sin && !par_bad;
  assign Busy       = (state != IDLE);

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!Sin) begin
            state   <= DATA;
            cnt     <= '0;
            par_bad <= 1'b0;
          end
        end
        DATA: begin
          // Right shift so the first bit received ends up at bit 0.
          shreg <= {Sin, shreg[DATA_W-1:1]};
          if (cnt == CW'(DATA_W - 1)) begin
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          par_bad <= ^{shreg, Sin};
          state   <= STOP;
        end
        STOP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Dout    <= '0;
      Dvalid  <= 1'b0;
      ParErr  <= 1'b0;
      FrmErr  <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      ParErr  <= 1'b0;
      FrmErr  <= 1'b0;
      Overrun <= 1'b0;
      if (state == STOP) begin
        if (!Sin) begin
          FrmErr <= 1'b1;
        end else if (par_bad) begin
          ParErr <= 1'b1;
        end
      end
      // A consumer handshake on the same edge frees the register for the new word.
      if (good_frame) begin
        if (!Dvalid || Dready) begin
          Dout   <= shreg;
          Dvalid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Dvalid && Dready) begin
        Dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed frames plus randomized frames, checked every cycle against a
// frame-level model of the output register and error pulses.
module tb_sipo_frame_rx;

  localparam int NONE = 0;
  localparam int GOOD = 1;
  localparam int PERR = 2;
  localparam int FERR = 3;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Sin;
  logic       Dready;
  logic [7:0] Dout;
  logic       Dvalid;
  logic       ParErr;
  logic       FrmErr;
  logic       Overrun;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  logic       exp_valid;
  logic [7:0] exp_dout;
  logic       exp_par;
  logic       exp_frm;
  logic       exp_ovr;
  logic       exp_busy;

  sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .Sin(Sin), .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready),
    .ParErr(ParErr), .FrmErr(FrmErr), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, want);
    end
  endtask

  task automatic check_cycle();
    check_output("Dvalid", 16'(Dvalid), 16'(exp_valid));
    if (exp_valid) check_output("Dout", 16'(Dout), 16'(exp_dout));
    check_output("ParErr", 16'(ParErr), 16'(exp_par));
    check_output("FrmErr", 16'(FrmErr), 16'(exp_frm));
    check_output("Overrun", 16'(Overrun), 16'(exp_ovr));
    check_output("Busy", 16'(Busy), 16'(exp_busy));
  endtask

  task automatic check_reset();
    check_output("rst_Dout", 16'(Dout), 16'h0);
    check_output("rst_Dvalid", 16'(Dvalid), 16'h0);
    check_output("rst_ParErr", 16'(ParErr), 16'h0);
    check_output("rst_FrmErr", 16'(FrmErr), 16'h0);
    check_output("rst_Overrun", 16'(Overrun), 16'h0);
    check_output("rst_Busy", 16'(Busy), 16'h0);
  endtask

  task automatic clear_model();
    exp_valid = 1'b0;
    exp_dout  = 8'h00;
    exp_par   = 1'b0;
    exp_frm   = 1'b0;
    exp_ovr   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // Drives one bit time; the model applies the frame outcome (known from how the frame was built) on that edge.
  task automatic apply_stimulus(input logic sin, input logic rdy, input int outcome,
                                input logic [7:0] word, input logic busy_after);
    Sin    = sin;
    Dready = rdy;
    @(negedge CLK);
    exp_par = (outcome == PERR);
    exp_frm = (outcome == FERR);
    exp_ovr = 1'b0;
    if (outcome == GOOD) begin
      if (!exp_valid || rdy) begin
        exp_valid = 1'b1;
        exp_dout  = word;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    exp_busy = busy_after;
    @(posedge CLK);
    check_cycle();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, rdy, NONE, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic flip_par, input logic stop_bit,
                            input logic rdy, input logic rdy_stop, input logic rand_rdy);
    logic pbit;
    int   outcome;
    pbit = logic'($countones(data) % 2) ^ flip_par;
    if (!stop_bit) outcome = FERR;
    else if ((($countones(data) + int'(pbit)) % 2) != 0) outcome = PERR;
    else outcome = GOOD;
    apply_stimulus(1'b0, rand_rdy ? logic'($urandom_range(0, 1)) : rdy, NONE, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)
      apply_stimulus(data[i], rand_rdy ? logic'($urandom_range(0, 1)) : rdy, NONE, 8'h00, 1'b1);
    apply_stimulus(pbit, rand_rdy ? logic'($urandom_range(0, 1)) : rdy, NONE, 8'h00, 1'b1);
    apply_stimulus(stop_bit, rand_rdy ? logic'($urandom_range(0, 1)) : rdy_stop, outcome, data, 1'b0);
  endtask

  initial begin
    logic [7:0] partial;
    RSTn   = 1'b1;
    Sin    = 1'b1;
    Dready = 1'b0;
    clear_model();
    #1 RSTn = 1'b0;
    #1 check_reset();
    repeat (2) @(posedge CLK);
    RSTn = 1'b1;
    idle(2, 1'b1);

    // Good frame, bad parity, framing error followed by a good frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Overrun: back-to-back frames with the consumer stalled, then drain.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Handshake on the exact stop edge lets the new word replace the old one.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);

    // Reset in the middle of a frame while a word is still held.
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    partial = 8'hF0;
    apply_stimulus(1'b0, 1'b0, NONE, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(partial[i], 1'b0, NONE, 8'h00, 1'b1);
    #1 RSTn = 1'b0;
    #1 check_reset();
    clear_model();
    @(negedge CLK);
    @(posedge CLK);
    RSTn = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Randomized frames, faults and consumer back-pressure.
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                 1'b0, 1'b0, 1'b1);
      idle(int'($urandom_range(0, 2)), logic'($urandom_range(0, 1)));
    end
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
